ccs_reg_scheduler: RTL and testbench
====================================

CCS_REG_SCHEDULER -- requirements
Module: ccs_reg_scheduler

Interface
REQ-001 The module SHALL have parameter N_REQ, default 2, meaning the number of register-access requesters (2..4).
REQ-002 The module SHALL have parameter ADDRESS, default 8'h20, meaning the 8-bit I2C write address of the sensor; read address = ADDRESS+1.
REQ-003 The module SHALL have port clk_in  input  1  system clock; all logic on rising edge.
REQ-004 The module SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have the following requester ports:
- req  input  N_REQ  level request per requester.
- req_read  input  N_REQ  1=register read, 0=register write.
- req_addr  input  16*N_REQ  register address, requester i at [16i+15:16i].
- req_wdata  input  8*N_REQ  write data, requester i at [8i+7:8i].
- grant  output  N_REQ  one-hot; current owner.
- done  output  N_REQ  one-cycle completion pulse to owner.
- rdata  output  8  read result, valid with done.
- err  output  1  one-cycle pulse with done when the access failed.
REQ-006 The module SHALL have the following i2c_master-side ports:
- i2c_address  output  8.
- transfer_start, transfer_continues  output  1 each.
- data_tx  output  8.
- transfer_ready, interrupt, nack, address_err  input  1 each.
- data_rx  input  8.

Function
REQ-007 The FSM SHALL have states IDLE, ADDR_MSB, ADDR_LSB, PAYLOAD, FINISH.
- IDLE: when any req is high, latch winner's read/addr/wdata, assert its grant, go to ADDR_MSB next cycle.
REQ-008 The module SHALL advance each byte step only in a cycle where transfer_ready or interrupt is high.
- ADDR_MSB: start=1, continues=1, i2c_address=ADDRESS, data_tx=addr[15:8].
- ADDR_LSB: start=0, continues=!read, data_tx=addr[7:0].
- PAYLOAD: write: start=0, continues=0, data_tx=wdata; read: start=1, continues=0, i2c_address=ADDRESS+1.
REQ-009 In FINISH, on the next interrupt the module SHALL pulse done[owner] for one cycle, drive rdata=data_rx (reads; 0 for writes), clear grant and return to IDLE.
REQ-010 The module SHALL treat an interrupt with address_err, or with nack during a write or address phase, as failure: start=0, continues=0, pulse done[owner] and err together, rdata=0, return to IDLE.
REQ-011 Read-data nack is expected protocol (master NACKs last byte) and SHALL NOT raise err.
REQ-012 The latched command SHALL be used for the whole transaction; req/addr changes after grant SHALL have no effect.
REQ-013 Deasserting req after grant SHALL NOT abort the transaction; done still pulses.
REQ-014 The module SHALL start a new arbitration no earlier than the cycle after done; minimum one IDLE cycle between transactions.
REQ-015 Exactly one grant bit SHALL be high outside IDLE; grant SHALL be all-zero in IDLE.

Reset
REQ-016 On reset_n low, asynchronously and regardless of state, the module SHALL enter IDLE with:
- grant=0, done=0, err=0, rdata=0.
- transfer_start=0, transfer_continues=0, data_tx=0, i2c_address=ADDRESS.
- round-robin pointer=0.
REQ-017 A reset mid-transaction SHALL produce no done pulse; the owner re-requests.

Configuration
REQ-018 With CCS_SCHED_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: search starts at index (last owner+1) mod N_REQ, pointer updates on grant.
REQ-019 Without CCS_SCHED_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, lowest index wins, and no pointer register exists.

Verification
REQ-020 Write: req[0], req_read=0, addr=16'h0160, wdata=8'h06 -> data_tx 8'h01, 8'h60, 8'h06; continues 1,1,0; start only on first byte; single done[0], err=0.
REQ-021 Read: req[1], req_read=1, addr=16'h0000; model returns 8'h02 -> second byte continues=0, restart with i2c_address=8'h21, done[1] with rdata=8'h02, err=0.
REQ-022 NACK on address LSB of write -> start=0, continues=0, done and err pulse same cycle, next IDLE cycle grant=0.
REQ-023 req=2'b11 held continuously for four transactions -> with macro grant order 0,1,0,1; without macro 0,0,0,0.
REQ-024 reset_n low during PAYLOAD of a write -> all outputs at reset values immediately, no done; after release, pending req is granted anew starting at ADDR_MSB.

Source files
------------

// File: rtl/ccs_reg_scheduler.sv
// ccs_reg_scheduler: arbitrates requesters onto an i2c_master for 16-bit-address sensor register reads/writes.
// Define CCS_SCHED_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module ccs_reg_scheduler #(
  parameter int         N_REQ   = 2,
  parameter logic [7:0] ADDRESS = 8'h20
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_read,
  input  logic [16*N_REQ-1:0]  req_addr,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           rdata,
  output logic                 err,
  output logic [7:0]           i2c_address,
  output logic                 transfer_start,
  output logic                 transfer_continues,
  output logic [7:0]           data_tx,
  input  logic                 transfer_ready,
  input  logic                 interrupt,
  input  logic                 nack,
  input  logic                 address_err,
  input  logic [7:0]           data_rx
);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [2:0] {IDLE, ADDR_MSB, ADDR_LSB, PAYLOAD, FINISH} state_t;
  state_t state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic [7:0] rdata_q, rdata_d, ia_q, ia_d, tx_q, tx_d, wd_q, wd_d;
  logic [15:0] addr_q, addr_d;
  logic err_q, err_d, start_q, start_d, cont_q, cont_d, rd_q, rd_d;
  logic [PW-1:0] win;
  logic take, step, fail;
  assign take = state_q == IDLE && |req && !done_q;
  assign step = transfer_ready | interrupt;
  // a nack on the final read byte is the master's normal end-of-read, not a failure
  assign fail = interrupt & (address_err | (nack & !(rd_q & state_q == FINISH)));
`ifdef CCS_SCHED_ROUND_ROBIN_EN
  logic [PW-1:0] ptr_q, ptr_d, ofs;
  logic [N_REQ-1:0] rot;
  logic [PW:0] sum;
  always_comb begin
    rot = N_REQ'({req, req} >> ptr_q);
    ofs = '0;
    for (int k = N_REQ - 1; k >= 0; k--) if (rot[k]) ofs = k[PW-1:0];
    sum = {1'b0, ptr_q} + {1'b0, ofs};
    win = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : sum[PW-1:0];
    ptr_d = take ? ((win == PW'(N_REQ - 1)) ? '0 : win + PW'(1)) : ptr_q;
  end
`else
  always_comb begin
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) if (req[k]) win = k[PW-1:0];
  end
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    ia_d    = ia_q;
    start_d = start_q;
    cont_d  = cont_q;
    tx_d    = tx_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    if (state_q != IDLE && fail) begin
      state_d = IDLE;
      grant_d = '0;
      done_d  = grant_q;
      err_d   = 1'b1;
      rdata_d = '0;
      start_d = 1'b0;
      cont_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (take) begin
          state_d = ADDR_MSB;
          grant_d = N_REQ'(1) << win;
          rd_d    = req_read[win];
          addr_d  = req_addr[16*win +: 16];
          wd_d    = req_wdata[8*win +: 8];
          ia_d    = ADDRESS;
          start_d = 1'b1;
          cont_d  = 1'b1;
          tx_d    = req_addr[16*win+8 +: 8];
        end
        ADDR_MSB: if (step) begin
          state_d = ADDR_LSB;
          start_d = 1'b0;
          cont_d  = !rd_q;
          tx_d    = addr_q[7:0];
        end
        ADDR_LSB: if (step) begin
          state_d = PAYLOAD;
          start_d = rd_q;
          cont_d  = 1'b0;
          ia_d    = rd_q ? ADDRESS + 8'd1 : ADDRESS;
          tx_d    = rd_q ? tx_q : wd_q;
        end
        PAYLOAD: if (step) begin
          state_d = FINISH;
          start_d = 1'b0;
          cont_d  = 1'b0;
        end
        FINISH: if (interrupt) begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = grant_q;
          rdata_d = rd_q ? data_rx : '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      ia_q    <= ADDRESS;
      start_q <= 1'b0;
      cont_q  <= 1'b0;
      tx_q    <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
`ifdef CCS_SCHED_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ia_q    <= ia_d;
      start_q <= start_d;
      cont_q  <= cont_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
`ifdef CCS_SCHED_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end
  assign grant              = grant_q;
  assign done               = done_q;
  assign err                = err_q;
  assign rdata              = rdata_q;
  assign i2c_address        = ia_q;
  assign transfer_start     = start_q;
  assign transfer_continues = cont_q;
  assign data_tx            = tx_q;
endmodule

// File: tb/tb_ccs_reg_scheduler.sv
// tb_ccs_reg_scheduler: directed and random register transactions against a phase-table reference model.
module tb_ccs_reg_scheduler;
  localparam logic [7:0] A = 8'h20;
  logic clk_in = 1'b0;
  logic reset_n = 1'b1;
  logic [1:0] req = '0, req_read = '0, grant, done;
  logic [31:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [7:0] rdata, i2c_address, data_tx, data_rx = '0;
  logic err, transfer_start, transfer_continues;
  logic transfer_ready = 1'b0, interrupt = 1'b0, nack = 1'b0, address_err = 1'b0;
  int checks = 0, errors = 0, rr_ptr = 0;
  bit after_done = 1'b0;
  logic [1:0] g;
  logic [1:0] exp_order [4];

  ccs_reg_scheduler dut (
    .clk_in(clk_in), .reset_n(reset_n), .req(req), .req_read(req_read), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .done(done), .rdata(rdata), .err(err),
    .i2c_address(i2c_address), .transfer_start(transfer_start), .transfer_continues(transfer_continues),
    .data_tx(data_tx), .transfer_ready(transfer_ready), .interrupt(interrupt), .nack(nack),
    .address_err(address_err), .data_rx(data_rx)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] rq);
`ifdef CCS_SCHED_ROUND_ROBIN_EN
    for (int k = 0; k < 2; k++) if (rq[(rr_ptr + k) % 2]) return (rr_ptr + k) % 2;
`else
    for (int k = 0; k < 2; k++) if (rq[k]) return k;
`endif
    return 0;
  endfunction

  task automatic clear_master();
    transfer_ready = 1'b0;
    interrupt = 1'b0;
    nack = 1'b0;
    address_err = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rr_ptr = 0;
    after_done = 1'b0;
    clear_master();
    #1;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_start", transfer_start, 0);
    check("rst_cont", transfer_continues, 0);
    check("rst_tx", data_tx, 0);
    check("rst_ia", i2c_address, A);
    tick();
    tick();
    check("rst_hold_done", done, 0);
    reset_n = 1'b1;
    tick();
  endtask

  // One full transaction; fail_ph in 0..3 injects a master error at that byte phase, -1 for none.
  task automatic run_txn(input logic [1:0] rq, input logic [1:0] rd, input logic [31:0] ad,
                         input logic [15:0] wd, input int fail_ph, input bit aerr_in,
                         input logic [7:0] rx, input bit scramble, output logic [1:0] gnt);
    int w, n, stall;
    bit rdw, aerr, rn;
    logic [15:0] a;
    logic [7:0] d;
    req = rq; req_read = rd; req_addr = ad; req_wdata = wd;
    w = pick(rq);
    rdw = rd[w];
    a = ad[16*w +: 16];
    d = wd[8*w +: 8];
    aerr = aerr_in | (fail_ph == 3 && rdw);
    tick();
    if (after_done) check("idle_gap", grant, 0);
    n = 0;
    while (grant == 2'b00 && n < 4) begin
      tick();
      n++;
    end
    gnt = grant;
    check("grant", grant, 1 << w);
    rr_ptr = (w + 1) % 2;
    if (scramble) begin
      req = 2'($urandom); req_read = 2'($urandom); req_addr = $urandom; req_wdata = 16'($urandom);
    end
    for (int ph = 0; ph < 4; ph++) begin
      stall = $urandom_range(0, 1);
      for (int s = 0; s <= stall; s++) begin
        if (s > 0) begin
          transfer_ready = (ph == 3);
          tick();
          clear_master();
        end
        check($sformatf("start_p%0d", ph), transfer_start, ph == 0 || (ph == 2 && rdw));
        check($sformatf("cont_p%0d", ph), transfer_continues, ph == 0 || (ph == 1 && !rdw));
        check($sformatf("ia_p%0d", ph), i2c_address, (ph >= 2 && rdw) ? A + 8'd1 : A);
        if (ph < 2 || (ph == 2 && !rdw))
          check($sformatf("tx_p%0d", ph), data_tx, ph == 0 ? a[15:8] : ph == 1 ? a[7:0] : d);
        check($sformatf("own_p%0d", ph), grant, 1 << w);
        check($sformatf("nodone_p%0d", ph), done, 0);
      end
      if (ph == fail_ph) begin
        interrupt = 1'b1;
        address_err = aerr;
        nack = !aerr;
        data_rx = 8'($urandom);
        tick();
        clear_master();
        check("fail_done", done, 1 << w);
        check("fail_err", err, 1);
        check("fail_rdata", rdata, 0);
        check("fail_grant", grant, 0);
        check("fail_start", transfer_start, 0);
        check("fail_cont", transfer_continues, 0);
        after_done = 1'b1;
        return;
      end
      if (ph < 3) begin
        if ($urandom_range(0, 1) == 1) transfer_ready = 1'b1;
        else interrupt = 1'b1;
      end else begin
        rn = rdw && ($urandom_range(0, 1) == 1);
        interrupt = 1'b1;
        nack = rn;
        data_rx = rx;
      end
      tick();
      clear_master();
    end
    check("ok_done", done, 1 << w);
    check("ok_err", err, 0);
    check("ok_rdata", rdata, rdw ? rx : 8'h00);
    check("ok_grant", grant, 0);
    after_done = 1'b1;
  endtask

  initial begin
`ifdef CCS_SCHED_ROUND_ROBIN_EN
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    #3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 2'($urandom), $urandom, 16'($urandom), -1, 1'b0, 8'($urandom), 1'b0, g);
      check($sformatf("order%0d", i), g, exp_order[i]);
    end
    run_txn(2'b01, 2'b00, 32'h0000_0160, 16'h0006, -1, 1'b0, 8'hAA, 1'b0, g);
    run_txn(2'b10, 2'b10, 32'h0000_1234, 16'h0000, -1, 1'b0, 8'h02, 1'b0, g);
    run_txn(2'b01, 2'b00, 32'h0000_0160, 16'h0006, 1, 1'b0, 8'h00, 1'b0, g);
    req = 2'b01; req_read = 2'b00; req_addr = 32'h0000_1234; req_wdata = 16'h0055;
    tick();
    for (int n = 0; n < 4 && grant == 2'b00; n++) tick();
    check("r24_grant", grant, 2'b01);
    transfer_ready = 1'b1;
    tick();
    tick();
    transfer_ready = 1'b0;
    check("r24_payload_tx", data_tx, 8'h55);
    #2;
    do_reset();
    run_txn(2'b01, 2'b00, 32'h0000_1234, 16'h0055, -1, 1'b0, 8'h00, 1'b0, g);
    for (int i = 0; i < 40; i++)
      run_txn(2'($urandom_range(1, 3)), 2'($urandom), $urandom, 16'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
              1'($urandom), 8'($urandom), 1'b1, g);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
